linescanner_pattern_mimic: RTL and testbench

Parametrised successor to the single-mode line-scanner mimic. It is a synthetic line-scan sensor source that emits configurable-width pixels at a divided pixel rate, in fixed-length lines separated by blanking gaps. Each line carries one of four selectable test patterns. It sits in place of a real sensor front end and feeds the capture/buffer path during bring-up and regression.

---
 rtl/linescanner_pattern_mimic.sv | 172 +++++++++++++++++
 tb/tb_linescanner_pattern_mimic.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/linescanner_pattern_mimic.sv
// Synthetic line-scan sensor source: divided pixel clock, fixed-length lines separated by blanking, four test patterns.
// Define LINESCANNER_MIMIC_FRAME_EN to add frame framing (LINES_PER_FRAME, frame_start, frame_end).
module linescanner_pattern_mimic #(
  parameter int PIXEL_WIDTH     = 8,
  parameter int PIXELS_PER_LINE = 1024,
  parameter int LINE_GAP        = 16,
  parameter int CLOCK_DIVIDER   = 2
`ifdef LINESCANNER_MIMIC_FRAME_EN
  ,
  parameter int LINES_PER_FRAME = 64
`endif
) (
  input  logic                   main_clock_source,
  input  logic                   n_reset,
  input  logic                   enable,
  input  logic [1:0]             pattern_mode,
  input  logic [PIXEL_WIDTH-1:0] const_value,
  output logic                   pixel_clock,
  output logic [PIXEL_WIDTH-1:0] pixel_data,
  output logic                   pixel_captured,
  output logic                   line_start,
  output logic                   line_end,
  output logic                   busy,
  output logic [15:0]            line_count
`ifdef LINESCANNER_MIMIC_FRAME_EN
  ,
  output logic                   frame_start,
  output logic                   frame_end
`endif
);
  localparam int DIV_W    = $clog2(CLOCK_DIVIDER);
  localparam int IDX_W    = $clog2(PIXELS_PER_LINE);
  localparam int GAP_W    = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  localparam int GAP_LAST = (LINE_GAP > 0) ? LINE_GAP - 1 : 0;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIVIDER - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLOCK_DIVIDER / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXELS_PER_LINE - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;

  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;

  logic [1:0]             state, state_next;
  logic [DIV_W-1:0]       div_cnt, div_next;
  logic [IDX_W-1:0]       pix_idx;
  logic [GAP_W-1:0]       gap_cnt;
  logic [15:0]            lfsr, lfsr_next;
  logic [15:0]            line_count_next;
  logic [1:0]             mode_q;
  logic [PIXEL_WIDTH-1:0] const_q;
  logic [PIXEL_WIDTH-1:0] pattern_value;
  logic                   tick, idx_last, gap_last, idx_b3;
  logic                   line_done, line_begin;

  assign tick      = (div_cnt == DIV_LAST);
  assign div_next  = tick ? '0 : div_cnt + DIV_W'(1);
  assign idx_last  = (pix_idx == IDX_LAST);
  assign gap_last  = (gap_cnt == GAP_W'(GAP_LAST));
  assign line_done = tick && (state == S_ACTIVE) && idx_last;
  // A new line begins from IDLE, at the end of the gap, or straight after the last pixel when there is no gap.
  assign line_begin = tick && enable &&
                      ((state == S_IDLE) || ((state == S_GAP) && gap_last) ||
                       ((state == S_ACTIVE) && idx_last && (LINE_GAP == 0)));
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign busy      = (state != S_IDLE);

  generate
    if (IDX_W > 3) begin : g_idx_b3
      assign idx_b3 = pix_idx[3];
    end else begin : g_idx_b3_zero
      assign idx_b3 = 1'b0;
    end
  endgenerate

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    if (line_begin)
      state_next = S_ACTIVE;
    else if (line_done)
      state_next = (LINE_GAP > 0) ? S_GAP : S_IDLE;
    else if (tick && (state == S_GAP) && gap_last)
      state_next = S_IDLE;
    else if (state == 2'd3)
      state_next = S_IDLE;
  end

  always_comb begin
    line_count_next = line_count + 16'd1;
`ifdef LINESCANNER_MIMIC_FRAME_EN
    if (line_count == 16'(LINES_PER_FRAME - 1))
      line_count_next = 16'd0;
`endif
  end

  always_comb begin
    pattern_value = {PIXEL_WIDTH{idx_b3 ^ line_count[0]}};
    case (mode_q)
      MODE_RAMP:  pattern_value = PIXEL_WIDTH'(pix_idx) + line_count[PIXEL_WIDTH-1:0];
      MODE_CONST: pattern_value = const_q;
      MODE_LFSR:  pattern_value = lfsr[PIXEL_WIDTH-1:0];
      default:    ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge main_clock_source or negedge n_reset) begin
    if (!n_reset) begin
      state          <= S_IDLE;
      div_cnt        <= '0;
      pix_idx        <= '0;
      gap_cnt        <= '0;
      lfsr           <= 16'hACE1;
      mode_q         <= '0;
      const_q        <= '0;
      pixel_clock    <= 1'b0;
      pixel_data     <= '0;
      pixel_captured <= 1'b0;
      line_start     <= 1'b0;
      line_end       <= 1'b0;
      line_count     <= '0;
`ifdef LINESCANNER_MIMIC_FRAME_EN
      frame_start    <= 1'b0;
      frame_end      <= 1'b0;
`endif
    end else begin
      state          <= state_next;
      div_cnt        <= div_next;
      pixel_clock    <= (div_next >= DIV_HALF);
      pixel_captured <= 1'b0;
      line_start     <= 1'b0;
      line_end       <= 1'b0;
`ifdef LINESCANNER_MIMIC_FRAME_EN
      frame_start    <= 1'b0;
      frame_end      <= 1'b0;
`endif
      if (line_begin) begin
        pix_idx <= '0;
        mode_q  <= pattern_mode;
        const_q <= const_value;
      end else if (tick && (state == S_ACTIVE)) begin
        pix_idx <= idx_last ? '0 : pix_idx + IDX_W'(1);
      end

      if (line_done)
        gap_cnt <= '0;
      else if (tick && (state == S_GAP))
        gap_cnt <= gap_cnt + GAP_W'(1);

      if (tick && (state == S_ACTIVE)) begin
        pixel_data     <= pattern_value;
        pixel_captured <= 1'b1;
        line_start     <= (pix_idx == '0);
        line_end       <= idx_last;
`ifdef LINESCANNER_MIMIC_FRAME_EN
        frame_start    <= (pix_idx == '0) && (line_count == 16'd0);
        frame_end      <= idx_last && (line_count == 16'(LINES_PER_FRAME - 1));
`endif
        if (mode_q == MODE_LFSR)
          lfsr <= lfsr_next;
      end

      if (line_done)
        line_count <= line_count_next;
    end
  end
endmodule

// File: tb/tb_linescanner_pattern_mimic.sv
// Self-checking bench for linescanner_pattern_mimic: two instances (8 and 16 pixels per line) against a pattern model.
// Strobes are captured into queues on the falling edge and compared with arithmetically derived expectations.
module tb_linescanner_pattern_mimic;
  localparam int W     = 8;
  localparam int GAP   = 2;
  localparam int CD    = 2;
  localparam int PPL_A = 8;
  localparam int PPL_B = 16;

  typedef struct {
    logic [7:0]  data;
    logic        ls;
    logic        le;
    logic [15:0] lc;
    int          cyc;
  } strobe_t;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        en [2];
  logic [1:0]  pattern_mode = 2'd0;
  logic [7:0]  const_value = 8'd0;
  logic        pclk [2];
  logic [7:0]  pdata [2];
  logic        pcap [2];
  logic        ls [2];
  logic        le [2];
  logic        busy [2];
  logic [15:0] lc [2];
`ifdef LINESCANNER_MIMIC_FRAME_EN
  logic        fs [2];
  logic        fe [2];
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  strobe_t q_a[$];
  strobe_t q_b[$];
  strobe_t mon_s;
  logic [15:0] m_lc [2];
  logic [15:0] m_lfsr [2];
  int prev_cyc [2];

  linescanner_pattern_mimic #(.PIXEL_WIDTH(W), .PIXELS_PER_LINE(PPL_A), .LINE_GAP(GAP), .CLOCK_DIVIDER(CD)) dut_a (
    .main_clock_source(clk), .n_reset(n_reset), .enable(en[0]), .pattern_mode(pattern_mode),
    .const_value(const_value), .pixel_clock(pclk[0]), .pixel_data(pdata[0]), .pixel_captured(pcap[0]),
    .line_start(ls[0]), .line_end(le[0]), .busy(busy[0]), .line_count(lc[0])
`ifdef LINESCANNER_MIMIC_FRAME_EN
    , .frame_start(fs[0]), .frame_end(fe[0])
`endif
  );

  linescanner_pattern_mimic #(.PIXEL_WIDTH(W), .PIXELS_PER_LINE(PPL_B), .LINE_GAP(GAP), .CLOCK_DIVIDER(CD)) dut_b (
    .main_clock_source(clk), .n_reset(n_reset), .enable(en[1]), .pattern_mode(pattern_mode),
    .const_value(const_value), .pixel_clock(pclk[1]), .pixel_data(pdata[1]), .pixel_captured(pcap[1]),
    .line_start(ls[1]), .line_end(le[1]), .busy(busy[1]), .line_count(lc[1])
`ifdef LINESCANNER_MIMIC_FRAME_EN
    , .frame_start(fs[1]), .frame_end(fe[1])
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pcap[0]) begin
      mon_s.data = pdata[0]; mon_s.ls = ls[0]; mon_s.le = le[0]; mon_s.lc = lc[0]; mon_s.cyc = cyc;
      q_a.push_back(mon_s);
    end
    if (pcap[1]) begin
      mon_s.data = pdata[1]; mon_s.ls = ls[1]; mon_s.le = le[1]; mon_s.lc = lc[1]; mon_s.cyc = cyc;
      q_b.push_back(mon_s);
    end
  end

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1: shift towards the MSB, feedback is the parity of the tapped bits.
  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    logic [15:0] taps;
    taps = 16'hB400;
    return {s[14:0], ^(s & taps)};
  endfunction

  function automatic logic [7:0] exp_pixel(input logic [1:0] mode, input int idx, input logic [15:0] lcnt,
                                           input logic [7:0] cval, input logic [15:0] lf);
    int v;
    case (mode)
      2'd0: begin v = (idx + int'(lcnt)) % 256; return 8'(v); end
      2'd1: return cval;
      2'd2: return lf[7:0];
      default: return ((((idx / 8) % 2) ^ (int'(lcnt) % 2)) != 0) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic pop(input int inst, output strobe_t r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (inst == 0 && q_a.size() > 0) begin r = q_a.pop_front(); ok = 1'b1; return; end
      if (inst == 1 && q_b.size() > 0) begin r = q_b.pop_front(); ok = 1'b1; return; end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_line(input int inst, input int ppl, input int npix, input logic [1:0] mode,
                            input logic [7:0] cval, input bit b2b, input int drop_at, input int chg_at,
                            input logic [1:0] chg_mode, input logic [7:0] chg_val, input string name);
    strobe_t r;
    bit ok;
    logic [7:0] exp_d;
    for (int idx = 0; idx < npix; idx++) begin
      pop(inst, r, ok);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL %s: no strobe for pixel %0d within 100 cycles", name, idx);
        return;
      end
      exp_d = exp_pixel(mode, idx, m_lc[inst], cval, m_lfsr[inst]);
      if (mode == 2'd2) m_lfsr[inst] = lfsr_adv(m_lfsr[inst]);
      if (r.data !== exp_d) begin
        tests_failed++;
        $display("FAIL %s: pixel %0d data got %h expected %h", name, idx, r.data, exp_d);
      end
      tests_run++;
      if (r.ls !== (idx == 0) || r.le !== (idx == ppl - 1)) begin
        tests_failed++;
        $display("FAIL %s: pixel %0d flags start/end got %b/%b expected %b/%b", name, idx, r.ls, r.le,
                 idx == 0, idx == ppl - 1);
      end
      if (idx > 0 || b2b) begin
        tests_run++;
        if (r.cyc - prev_cyc[inst] != ((idx > 0) ? CD : (GAP + 1) * CD)) begin
          tests_failed++;
          $display("FAIL %s: pixel %0d strobe spacing got %0d expected %0d", name, idx,
                   r.cyc - prev_cyc[inst], (idx > 0) ? CD : (GAP + 1) * CD);
        end
      end
      prev_cyc[inst] = r.cyc;
      if (idx == ppl - 1) begin
        m_lc[inst] = m_lc[inst] + 16'd1;
        tests_run++;
        if (r.lc !== m_lc[inst]) begin
          tests_failed++;
          $display("FAIL %s: line_count got %0d expected %0d", name, r.lc, m_lc[inst]);
        end
      end
      if (idx == chg_at) begin pattern_mode = chg_mode; const_value = chg_val; end
      if (idx == drop_at) en[inst] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int inst, input string name);
    int n;
    n = 0;
    while (busy[inst] !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (busy[inst] !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: busy got %b expected 0 after 100 cycles", name, busy[inst]);
    end
  endtask

  task automatic check_zero(input string name);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if ({pclk[i], pdata[i], pcap[i], ls[i], le[i], busy[i], lc[i]} !== '0) begin
        tests_failed++;
        $display("FAIL %s: inst %0d outputs got clk=%b data=%h cap=%b ls=%b le=%b busy=%b lc=%0d expected all 0",
                 name, i, pclk[i], pdata[i], pcap[i], ls[i], le[i], busy[i], lc[i]);
      end
    end
  endtask

  task automatic apply_reset(input string name);
    @(posedge clk); #1;
    n_reset = 1'b0;
    en[0] = 1'b0;
    en[1] = 1'b0;
    #1;
    check_zero(name);
    q_a.delete();
    q_b.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    for (int i = 0; i < 2; i++) begin m_lc[i] = 16'd0; m_lfsr[i] = 16'hACE1; end
    repeat (10) @(posedge clk);
    #1;
    tests_run++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      tests_failed++;
      $display("FAIL %s: strobes after reset release got %0d/%0d expected 0/0", name, q_a.size(), q_b.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_hold");
    @(negedge clk);
    n_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_pixel_clock();
    int highs, trans;
    logic prev;
    highs = 0; trans = 0;
    prev = pclk[0];
    for (int i = 0; i < 4 * CD; i++) begin
      @(posedge clk); #1;
      if (pclk[0] === 1'b1) highs++;
      if (pclk[0] !== prev) trans++;
      prev = pclk[0];
    end
    tests_run++;
    if (highs != 2 * CD) begin
      tests_failed++;
      $display("FAIL pixel_clock_duty: high samples got %0d expected %0d", highs, 2 * CD);
    end
    tests_run++;
    if (trans != 8) begin
      tests_failed++;
      $display("FAIL pixel_clock_period: transitions got %0d expected 8", trans);
    end
  endtask

  task automatic test_ramp();
    pattern_mode = 2'd0;
    en[0] = 1'b1;
    check_line(0, PPL_A, PPL_A, 2'd0, 8'h00, 1'b0, -1, -1, 2'd0, 8'h00, "ramp_line0");
    check_line(0, PPL_A, PPL_A, 2'd0, 8'h00, 1'b1, 0, -1, 2'd0, 8'h00, "ramp_line1");
    wait_idle(0, "ramp_idle");
  endtask

  task automatic test_constant();
    pattern_mode = 2'd1;
    const_value = 8'hA5;
    en[0] = 1'b1;
    check_line(0, PPL_A, PPL_A, 2'd1, 8'hA5, 1'b0, -1, 3, 2'd1, 8'h3C, "const_line0");
    check_line(0, PPL_A, PPL_A, 2'd1, 8'h3C, 1'b1, 0, -1, 2'd1, 8'h3C, "const_line1");
    wait_idle(0, "const_idle");
  endtask

  task automatic test_lfsr();
    apply_reset("lfsr_reset");
    pattern_mode = 2'd2;
    en[0] = 1'b1;
    check_line(0, PPL_A, PPL_A, 2'd2, 8'h00, 1'b0, -1, -1, 2'd2, 8'h00, "lfsr_line0");
    check_line(0, PPL_A, PPL_A, 2'd2, 8'h00, 1'b1, 0, -1, 2'd2, 8'h00, "lfsr_line1");
    wait_idle(0, "lfsr_idle");
  endtask

  task automatic test_checkerboard();
    apply_reset("checker_reset");
    pattern_mode = 2'd3;
    en[0] = 1'b1;
    check_line(0, PPL_A, PPL_A, 2'd3, 8'h00, 1'b0, -1, -1, 2'd3, 8'h00, "checker8_line0");
    check_line(0, PPL_A, PPL_A, 2'd3, 8'h00, 1'b1, 0, -1, 2'd3, 8'h00, "checker8_line1");
    wait_idle(0, "checker8_idle");
    en[1] = 1'b1;
    check_line(1, PPL_B, PPL_B, 2'd3, 8'h00, 1'b0, -1, -1, 2'd3, 8'h00, "checker16_line0");
    check_line(1, PPL_B, PPL_B, 2'd3, 8'h00, 1'b1, 0, -1, 2'd3, 8'h00, "checker16_line1");
    wait_idle(1, "checker16_idle");
  endtask

  task automatic test_enable_drop();
    logic [1:0] m;
    logic [7:0] c;
    m = 2'($urandom_range(0, 3));
    c = 8'($urandom);
    pattern_mode = m;
    const_value = c;
    en[0] = 1'b1;
    check_line(0, PPL_A, PPL_A, m, c, 1'b0, 3, -1, m, c, "drop_line");
    tests_run++;
    if (busy[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL drop_gap_busy: busy got %b expected 1", busy[0]);
    end
    wait_idle(0, "drop_idle");
    repeat (30) @(posedge clk);
    #1;
    tests_run++;
    if (q_a.size() != 0 || busy[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_quiet: strobes got %0d busy got %b expected 0/0", q_a.size(), busy[0]);
    end
  endtask

  task automatic test_reset_midline();
    pattern_mode = 2'd2;
    en[0] = 1'b1;
    check_line(0, PPL_A, 4, 2'd2, 8'h00, 1'b0, -1, -1, 2'd2, 8'h00, "midreset_partial");
    apply_reset("midreset_async");
    en[0] = 1'b1;
    check_line(0, PPL_A, PPL_A, 2'd2, 8'h00, 1'b0, 0, -1, 2'd2, 8'h00, "midreset_restart");
    wait_idle(0, "midreset_idle");
  endtask

  task automatic test_back_to_back();
    logic [1:0] modes [6];
    logic [7:0] cvals [6];
    for (int k = 0; k < 6; k++) begin
      modes[k] = 2'($urandom_range(0, 3));
      cvals[k] = 8'($urandom);
    end
    pattern_mode = modes[0];
    const_value = cvals[0];
    en[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4)
        check_line(0, PPL_A, PPL_A, modes[k], cvals[k], k > 0, -1, int'($urandom_range(0, PPL_A - 1)),
                   modes[k + 1], cvals[k + 1], "b2b_line");
      else
        check_line(0, PPL_A, PPL_A, modes[k], cvals[k], 1'b1, int'($urandom_range(0, PPL_A - 1)), -1,
                   modes[5], cvals[5], "b2b_last");
    end
    wait_idle(0, "b2b_idle");
  endtask

  initial begin
    en[0] = 1'b0;
    en[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin m_lc[i] = 16'd0; m_lfsr[i] = 16'hACE1; prev_cyc[i] = 0; end
    test_reset();
    test_pixel_clock();
    test_ramp();
    test_constant();
    test_lfsr();
    test_checkerboard();
    test_enable_drop();
    test_reset_midline();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
